// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator
// Function : sums NUM_TERMS signed products, sticky overflow; optional
//            saturation when MAC_SATURATE_EN is defined.
// Revision : 1.0
// ============================================================================
module mac_accumulator #(
  parameter int PROD_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int NUM_TERMS  = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PROD_WIDTH-1:0] prod_in,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  acc_valid,
  input  logic                  acc_ready,
  output logic                  busy,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_last = CNT_WIDTH'(NUM_TERMS - 1);

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0]   w_prod_ext;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic [ACC_WIDTH-1:0]   w_sum_res;
  logic                   w_add_ovf;

  generate
    if (ACC_WIDTH > PROD_WIDTH) begin : g_sign_ext
      assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_in[PROD_WIDTH-1]}}, prod_in};
    end else begin : g_no_ext
      assign w_prod_ext = prod_in;
    end
  endgenerate

  assign w_sum     = acc_q + w_prod_ext;
  // Same-sign operands producing a result of the other sign.
  assign w_add_ovf = (acc_q[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                     (w_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

`ifdef MAC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  assign w_sum_res = w_add_ovf ? (w_prod_ext[ACC_WIDTH-1] ? c_acc_min : c_acc_max)
                               : w_sum;
`else
  assign w_sum_res = w_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          acc_d = w_sum_res;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (w_add_ovf) ovf_d = 1'b1;
          if (cnt_q == c_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (acc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign prod_ready = (state_q == ACCUM);
  assign acc_valid  = (state_q == HOLD);
  assign busy       = (state_q != IDLE);
  assign acc_out    = acc_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accumulator
// Function : scoreboard bench driving a 40-bit and a 34-bit accumulator.
// Revision : 1.0
// ============================================================================
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] prod_in = '0;
  logic        prod_valid = 1'b0;
  logic        acc_ready = 1'b0;

  logic        prod_ready40, acc_valid40, busy40, ovf40;
  logic [39:0] acc_out40;
  logic        prod_ready34, acc_valid34, busy34, ovf34;
  logic [33:0] acc_out34;

  always #5 clk = ~clk;

  mac_accumulator #(.PROD_WIDTH(32), .ACC_WIDTH(40), .NUM_TERMS(8), .CNT_WIDTH(4)) u_dut40 (
    .clk(clk), .rst(rst), .start(start), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready40), .acc_out(acc_out40), .acc_valid(acc_valid40),
    .acc_ready(acc_ready), .busy(busy40), .overflow(ovf40)
  );

  mac_accumulator #(.PROD_WIDTH(32), .ACC_WIDTH(34), .NUM_TERMS(8), .CNT_WIDTH(4)) u_dut34 (
    .clk(clk), .rst(rst), .start(start), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready34), .acc_out(acc_out34), .acc_valid(acc_valid34),
    .acc_ready(acc_ready), .busy(busy34), .overflow(ovf34)
  );

  typedef struct {
    logic [39:0] a40;
    logic        o40;
    logic [33:0] a34;
    logic        o34;
  } exp_t;

  exp_t sb[$];
  int   prods[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: exact integer sum, folded back into range on overflow.
  function automatic void model(input int w, output longint acc, output bit ovf);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    longint m  = longint'(1) <<< w;
    acc = 0;
    ovf = 1'b0;
    foreach (prods[i]) begin
      acc += longint'(prods[i]);
      if (acc > hi || acc < lo) begin
        ovf = 1'b1;
`ifdef MAC_SATURATE_EN
        acc = (acc > hi) ? hi : lo;
`else
        acc = (acc > hi) ? acc - m : acc + m;
`endif
      end
    end
  endfunction

  // Monitor: scores each result as the consumer takes it.
  always @(negedge clk) begin
    if (!rst && acc_valid40 && acc_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("acc_out40", acc_out40, e.a40);
        check("overflow40", ovf40, e.o40);
        check("acc_valid34", acc_valid34, 1);
        check("acc_out34", acc_out34, e.a34);
        check("overflow34", ovf34, e.o34);
      end
    end
  end

  task automatic run_seq(input int max_gap, input int hold, input bit start_in_hold);
    exp_t        e;
    longint      a;
    bit          o;
    logic [63:0] t;
    logic [39:0] held40;
    logic [33:0] held34;
    model(40, a, o); t = a; e.a40 = t[39:0]; e.o40 = o;
    model(34, a, o); t = a; e.a34 = t[33:0]; e.o34 = o;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy40, 1);
    check("ovf_cleared40", ovf40, 0);
    check("ovf_cleared34", ovf34, 0);
    foreach (prods[i]) begin
      repeat ($urandom_range(max_gap, 0)) begin
        prod_valid = 1'b0;
        prod_in    = $urandom;
        @(posedge clk); #1;
      end
      prod_valid = 1'b1;
      prod_in    = prods[i];
      @(posedge clk); #1;
      prod_valid = 1'b0;
    end
    sb.push_back(e);
    check("valid_latency40", acc_valid40, 1);
    check("valid_latency34", acc_valid34, 1);
    check("ready_low_hold", prod_ready40, 0);
    held40 = acc_out40;
    held34 = acc_out34;
    repeat (hold) begin
      acc_ready = 1'b0;
      start     = start_in_hold;
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_valid", acc_valid40, 1);
      check("hold_stable40", acc_out40, held40);
      check("hold_stable34", acc_out34, held34);
      check("hold_prod_ready", prod_ready40, 0);
    end
    acc_ready = 1'b1;
    start     = start_in_hold;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    start     = 1'b0;
    check("idle_after_take", busy40, 0);
    check("valid_drop", acc_valid40, 0);
    @(posedge clk); #1;
    check("stay_idle", busy34, 0);
    check("result_kept", acc_out40, held40);
  endtask

  task automatic fill(input int v);
    prods.delete();
    repeat (8) prods.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_acc_out", acc_out40, 0);
    check("rst_acc_valid", acc_valid40, 0);
    check("rst_prod_ready", prod_ready40, 0);
    check("rst_busy", busy40, 0);
    check("rst_overflow", ovf34, 0);
    rst = 1'b0;
    @(negedge clk);

    prods.delete();
    for (int i = 1; i <= 8; i++) prods.push_back(i);
    run_seq(0, 0, 1'b0);
    check("basic_sum", acc_out40, 40'd36);

    fill(-5);
    run_seq(2, 1, 1'b0);
    check("neg_sum40", acc_out40, 40'hFFFFFFFFD8);

    prods.delete();
    repeat (8) prods.push_back(int'($urandom_range(1000, 0)) - 500);
    run_seq(1, 3, 1'b1);

    fill(32'h7FFFFFFF);
    run_seq(0, 0, 1'b0);
    check("ovf_flag34", ovf34, 1);
    check("no_ovf40", ovf40, 0);
`ifdef MAC_SATURATE_EN
    check("ovf_sum34", acc_out34, 34'h1FFFFFFFF);
`else
    check("ovf_sum34", acc_out34, 34'h3FFFFFFF8);
`endif

    fill(1);
    run_seq(0, 0, 1'b0);
    check("sticky_clear_sum", acc_out34, 34'd8);
    check("sticky_clear_flag", ovf34, 0);

    // Abort after three transfers with a mid-cycle reset.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    prod_valid = 1'b1;
    prod_in    = 32'd7;
    repeat (3) @(posedge clk);
    #2;
    prod_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_acc", acc_out40, 0);
    check("mid_rst_busy", busy40, 0);
    check("mid_rst_ready", prod_ready34, 0);
    @(negedge clk);
    rst = 1'b0;
    fill(2);
    run_seq(0, 0, 1'b0);
    check("post_rst_sum", acc_out40, 40'd16);

    for (int r = 0; r < 20; r++) begin
      prods.delete();
      repeat (8) prods.push_back(int'($urandom));
      run_seq(2, int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Downstream stage of the radix-4 Booth multiplier in the multi-bit MAC datapath. It consumes signed products over a valid/ready handshake and accumulates NUM_TERMS of them into a wider signed accumulator. It then presents the dot-product result on a valid/ready output port. Overflow is tracked with a sticky flag; saturation is optional.

Parameters:
PROD_WIDTH, 32, width of the signed two's-complement product from the multiplier
ACC_WIDTH, 40, width of the signed accumulator and result; must be >= PROD_WIDTH
NUM_TERMS, 8, products summed per result; must be >= 1
CNT_WIDTH, 4, term counter width; must satisfy 2**CNT_WIDTH >= NUM_TERMS

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse that begins a new accumulation; honoured only in IDLE
prod_in  input  PROD_WIDTH  signed product from the multiplier
prod_valid  input  1  prod_in is valid
prod_ready  output  1  block accepts prod_in this cycle
acc_out  output  ACC_WIDTH  signed accumulated result
acc_valid  output  1  acc_out holds a completed result
acc_ready  input  1  consumer takes acc_out
busy  output  1  high in ACCUM and HOLD
overflow  output  1  sticky signed-overflow flag for the current accumulation

Behaviour:
- Reset (async, rst=1): state=IDLE, acc register=0, term count=0, acc_out=0, acc_valid=0, prod_ready=0, busy=0, overflow=0. Asserting rst mid-accumulation discards all partial work; no result is emitted.
- All outputs are registered or decoded purely from state. acc_out always reflects the accumulator register.
- States and transitions:
  - IDLE: prod_ready=0, acc_valid=0. When start=1, on the next edge: acc=0, count=0, overflow=0, state goes to ACCUM.
  - ACCUM: prod_ready=1. A transfer occurs on an edge where prod_valid && prod_ready. Each transfer sign-extends prod_in to ACC_WIDTH and adds it to acc, and count increments. The transfer with count==NUM_TERMS-1 moves the block to HOLD. Cycles with prod_valid=0 change nothing.
  - HOLD: prod_ready=0, acc_valid=1, and acc_out is stable. On an edge with acc_ready=1 the block returns to IDLE and acc_valid drops. acc_out and overflow keep their values until the next start.
- Latency: acc_valid rises on the edge that accepts the final product, so the result is visible in the cycle after the last transfer.
- start is ignored while busy=1. If start and acc_ready are both 1 in HOLD, the block only goes to IDLE; a new start is needed.
- Overflow is detected as signed overflow of the ACC_WIDTH addition: both operands have the same sign and the sum sign differs. It sets the overflow flag, which stays set until the next start. Without the optional feature, the sum wraps modulo 2**ACC_WIDTH.
- NUM_TERMS=1: a single transfer goes directly to HOLD.

Optional Feature:
MAC_SATURATE_EN
- Defined: on overflow, acc is clamped to the most positive value (2**(ACC_WIDTH-1)-1) or the most negative value (-2**(ACC_WIDTH-1)), matching the sign of the addend. Later additions operate on the clamped value. The overflow flag still sets.
- Not defined: acc wraps, and the overflow flag alone reports the event.
- Handshake and timing are identical in both builds.

Test Plan:
- Basic sum: start, then 8 back-to-back products 1..8 with acc_ready=1 -> acc_valid exactly one cycle after the 8th transfer, acc_out=36, overflow=0.
- Negatives and gaps: products of -5 with prod_valid low 2 cycles between each -> acc_out=-40 (0xFFFFFFFFD8 at ACC_WIDTH=40); no accumulation during the gaps.
- Backpressure: hold acc_ready=0 for 3 cycles in HOLD -> acc_valid stays 1, acc_out stays constant, prod_ready=0. A start pulse during HOLD is ignored. After acc_ready=1 the block is in IDLE.
- Overflow, ACC_WIDTH=34, eight products of 0x7FFFFFFF:
  - without the macro -> acc_out=-8 (wrapped), overflow=1;
  - with MAC_SATURATE_EN -> acc_out=0x1FFFFFFFF, overflow=1.
  - A following start clears overflow.
- Reset mid-operation: assert rst asynchronously after 3 transfers -> acc_out=0, busy=0, prod_ready=0 immediately. A new start plus 8 products of 2 -> acc_out=16.
- Sticky clear: after an overflowed run, start a new run of 8 products of 1 -> acc_out=8, overflow=0.
